// File: rtl/riio_gpo_bank_ctrl.sv
// rtl/riio_gpo_bank_ctrl.sv - GPO pad bank control with break-before-make channel reconfiguration
module riio_gpo_bank_ctrl #(
    parameter int N          = 8,
    parameter int HOLD_CYC   = 4,
    parameter int SETTLE_CYC = 8,
    parameter int CHW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic             CLK_I,
    input  logic             RSTN_I,
    input  logic [N-1:0]     DO_I,
    input  logic [N-1:0]     OE_I,
    input  logic             CFG_VALID_I,
    output logic             CFG_READY_O,
    input  logic [CHW-1:0]   CFG_CH_I,
    input  logic [1:0]       CFG_DS_I,
    input  logic             CFG_SR_I,
    input  logic [1:0]       CFG_MODE_I,
    output logic             CFG_ERR_O,
    input  logic             VBIAS_OK_I,
    output logic             BUSY_O,
    output logic [N-1:0]     PAD_DO_O,
    output logic [N-1:0]     PAD_OE_O,
    output logic [2*N-1:0]   PAD_DS_O,
    output logic [N-1:0]     PAD_SR_O,
    output logic [N-1:0]     PAD_ODP_O,
    output logic [N-1:0]     PAD_ODN_O
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BREAK  = 2'd1;
    localparam logic [1:0] S_APPLY  = 2'd2;
    localparam logic [1:0] S_SETTLE = 2'd3;

    localparam int CNTW = 16;
    localparam logic [CNTW-1:0] HOLD_LOAD   = CNTW'(HOLD_CYC - 1);
    localparam logic [CNTW-1:0] SETTLE_LOAD = CNTW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

    logic [1:0]      state, state_nx;
    logic [CNTW-1:0] cnt, cnt_nx;
    logic            rdy, err, err_nx, apply, accept;

    logic [CHW-1:0]  lat_ch;
    logic [1:0]      lat_ds, lat_mode;
    logic            lat_sr;

    logic [2*N-1:0]  ds_st, mode_st;
    logic [N-1:0]    sr_st;

    logic            vb_meta, vb_ok;

    logic [31:0]     ch_ext, lat_ch_ext;
    logic            ch_bad, oe_sel;
    logic [N-1:0]    oe_sh, gate, oe_nx, odp_nx, odn_nx;

    assign ch_ext     = 32'(CFG_CH_I);
    assign lat_ch_ext = 32'(lat_ch);
    assign ch_bad     = (ch_ext >= N);
    assign oe_sh      = PAD_OE_O >> CFG_CH_I;
    assign oe_sel     = oe_sh[0];
    assign accept     = CFG_VALID_I & rdy & (state == S_IDLE);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        err_nx   = 1'b0;
        apply    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (ch_bad) begin
                        err_nx = 1'b1;
                    end else if (oe_sel) begin
                        state_nx = S_BREAK;
                        cnt_nx   = HOLD_LOAD;
                    end else begin
                        state_nx = S_APPLY;
                    end
                end
            end
            S_BREAK: begin
                if (cnt == '0) state_nx = S_APPLY;
                else           cnt_nx   = cnt - 1'b1;
            end
            S_APPLY: begin
                apply = 1'b1;
                if (SETTLE_CYC == 0) begin
                    state_nx = S_IDLE;
                end else begin
                    state_nx = S_SETTLE;
                    cnt_nx   = SETTLE_LOAD;
                end
            end
            S_SETTLE: begin
                if (cnt == '0) state_nx = S_IDLE;
                else           cnt_nx   = cnt - 1'b1;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Ready is registered so it stays low while reset is held and rises on the first edge after release.
    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rdy      <= 1'b0;
            err      <= 1'b0;
            lat_ch   <= '0;
            lat_ds   <= 2'b00;
            lat_sr   <= 1'b0;
            lat_mode <= 2'b11;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            rdy   <= (state_nx == S_IDLE);
            err   <= err_nx;
            if (accept) begin
                lat_ch   <= CFG_CH_I;
                lat_ds   <= CFG_DS_I;
                lat_sr   <= CFG_SR_I;
                lat_mode <= CFG_MODE_I;
            end
        end
    end

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            ds_st   <= '0;
            sr_st   <= '0;
            mode_st <= '1;
        end else if (apply) begin
            for (int i = 0; i < N; i++) begin
                if (lat_ch_ext == i) begin
                    ds_st[2*i +: 2]   <= lat_ds;
                    sr_st[i]          <= lat_sr;
                    mode_st[2*i +: 2] <= lat_mode;
                end
            end
        end
    end

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            vb_meta <= 1'b0;
            vb_ok   <= 1'b0;
        end else begin
            vb_meta <= VBIAS_OK_I;
            vb_ok   <= vb_meta;
        end
    end

    // Bias loss drops any non-minimum drive channel straight away, independent of the FSM.
    always_comb begin
        gate   = '0;
        oe_nx  = '0;
        odp_nx = '0;
        odn_nx = '0;
        for (int i = 0; i < N; i++) begin
            gate[i]   = (state != S_IDLE) && (lat_ch_ext == i);
            oe_nx[i]  = OE_I[i] && (mode_st[2*i +: 2] != 2'b11) && !gate[i]
                        && ((ds_st[2*i +: 2] == 2'b00) || vb_ok);
            odp_nx[i] = (mode_st[2*i +: 2] == 2'b10);
            odn_nx[i] = (mode_st[2*i +: 2] == 2'b01);
        end
    end

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            PAD_DO_O  <= '0;
            PAD_OE_O  <= '0;
            PAD_DS_O  <= '0;
            PAD_SR_O  <= '0;
            PAD_ODP_O <= '0;
            PAD_ODN_O <= '0;
        end else begin
            PAD_DO_O  <= DO_I;
            PAD_OE_O  <= oe_nx;
            PAD_DS_O  <= ds_st;
            PAD_SR_O  <= sr_st;
            PAD_ODP_O <= odp_nx;
            PAD_ODN_O <= odn_nx;
        end
    end

    assign CFG_READY_O = rdy;
    assign CFG_ERR_O   = err;
    assign BUSY_O      = (state != S_IDLE);

endmodule

// File: tb/tb_riio_gpo_bank_ctrl.sv
// tb/tb_riio_gpo_bank_ctrl.sv - randomized bench against a timeline-based reference model
module tb_riio_gpo_bank_ctrl;

    localparam int N      = 8;
    localparam int HOLD   = 4;
    localparam int SETTLE = 8;
    localparam int CHW    = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic [N-1:0]     do_i, oe_i;
    logic             cfg_valid, cfg_ready, cfg_sr, cfg_err, vbias, busy;
    logic [CHW-1:0]   cfg_ch;
    logic [1:0]       cfg_ds, cfg_mode;
    logic [N-1:0]     pad_do, pad_oe, pad_sr, pad_odp, pad_odn;
    logic [2*N-1:0]   pad_ds;

    riio_gpo_bank_ctrl #(.N(N), .HOLD_CYC(HOLD), .SETTLE_CYC(SETTLE), .CHW(CHW)) dut (
        .CLK_I(clk), .RSTN_I(rstn), .DO_I(do_i), .OE_I(oe_i),
        .CFG_VALID_I(cfg_valid), .CFG_READY_O(cfg_ready), .CFG_CH_I(cfg_ch),
        .CFG_DS_I(cfg_ds), .CFG_SR_I(cfg_sr), .CFG_MODE_I(cfg_mode),
        .CFG_ERR_O(cfg_err), .VBIAS_OK_I(vbias), .BUSY_O(busy),
        .PAD_DO_O(pad_do), .PAD_OE_O(pad_oe), .PAD_DS_O(pad_ds),
        .PAD_SR_O(pad_sr), .PAD_ODP_O(pad_odp), .PAD_ODN_O(pad_odn)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int k = 0;

    // Reference state: per-channel settings plus the timeline of the one in-flight request.
    logic [1:0]     m_ds [N];
    logic           m_sr [N];
    logic [1:0]     m_mode [N];
    logic [N-1:0]   e_do, e_oe, e_sr, e_odp, e_odn;
    logic [2*N-1:0] e_ds;
    logic           e_err, e_rdy, e_busy;
    logic           vb_hist1, vb_hist2;
    int             seq_end, apply_edge, seq_ch;
    logic           seq_brk;
    logic [1:0]     l_ds, l_mode;
    logic           l_sr;
    logic           pend, brk_rst_req;
    int             rst_hold;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h edge=%0d", tag, got, exp, k);
        end
    endtask

    task automatic check_all();
        check("pad_do", 64'(pad_do), 64'(e_do));
        check("pad_oe", 64'(pad_oe), 64'(e_oe));
        check("pad_ds", 64'(pad_ds), 64'(e_ds));
        check("pad_sr", 64'(pad_sr), 64'(e_sr));
        check("pad_odp", 64'(pad_odp), 64'(e_odp));
        check("pad_odn", 64'(pad_odn), 64'(e_odn));
        check("ready", 64'(cfg_ready), 64'(e_rdy));
        check("busy", 64'(busy), 64'(e_busy));
        check("err", 64'(cfg_err), 64'(e_err));
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_ds[i] = 2'b00; m_sr[i] = 1'b0; m_mode[i] = 2'b11;
        end
        e_do = '0; e_oe = '0; e_ds = '0; e_sr = '0; e_odp = '0; e_odn = '0;
        e_err = 0; e_rdy = 0; e_busy = 0;
        vb_hist1 = 0; vb_hist2 = 0;
        seq_end = -1; apply_edge = -1; seq_ch = -1; seq_brk = 0;
    endtask

    task automatic model_edge();
        logic [N-1:0] old_oe;
        logic         rdy_before, gate, vb_now;
        old_oe     = e_oe;
        rdy_before = e_rdy;
        vb_now     = vb_hist2;
        for (int i = 0; i < N; i++) begin
            gate = (k <= seq_end) && (seq_ch == i);
            e_do[i]       = do_i[i];
            e_oe[i]       = oe_i[i] && (m_mode[i] != 2'b11) && !gate && ((m_ds[i] == 2'b00) || vb_now);
            e_ds[2*i +: 2] = m_ds[i];
            e_sr[i]       = m_sr[i];
            e_odp[i]      = (m_mode[i] == 2'b10);
            e_odn[i]      = (m_mode[i] == 2'b01);
        end
        if (k == apply_edge) begin
            m_ds[seq_ch] = l_ds; m_sr[seq_ch] = l_sr; m_mode[seq_ch] = l_mode;
        end
        vb_hist2 = vb_hist1;
        vb_hist1 = vbias;
        e_err = 0;
        if (cfg_valid && rdy_before) begin
            pend = 0;
            if (int'(cfg_ch) >= N) begin
                e_err = 1;
            end else begin
                seq_brk    = old_oe[cfg_ch];
                apply_edge = k + (seq_brk ? HOLD : 0) + 1;
                seq_end    = apply_edge + SETTLE;
                seq_ch     = int'(cfg_ch);
                l_ds = cfg_ds; l_sr = cfg_sr; l_mode = cfg_mode;
            end
        end
        e_rdy  = (k >= seq_end);
        e_busy = !e_rdy;
        k++;
    endtask

    task automatic drive_inputs();
        do_i = N'($urandom);
        oe_i = N'($urandom | $urandom);
        if ($urandom % 48 == 0) vbias = ~vbias;
        if (!pend && ($urandom % 3 == 0)) begin
            pend     = 1;
            cfg_ch   = ($urandom % 8 == 0) ? CHW'(8 + $urandom % 8) : CHW'($urandom % 8);
            cfg_ds   = 2'($urandom);
            cfg_sr   = 1'($urandom);
            cfg_mode = ($urandom % 5 == 0) ? 2'b11 : 2'($urandom % 3);
        end
        cfg_valid = pend;
    endtask

    initial begin
        rstn = 0; do_i = '0; oe_i = '1; vbias = 1; cfg_valid = 0;
        cfg_ch = '0; cfg_ds = '0; cfg_sr = 0; cfg_mode = '0;
        pend = 0; brk_rst_req = 0; rst_hold = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        rstn = 1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            if (rstn) model_edge();
            @(negedge clk);
            check_all();
            if (!rstn) begin
                if (rst_hold == 0) rstn = 1;
                else rst_hold--;
            end else if (($urandom % 700 == 0) || (brk_rst_req && seq_brk && (apply_edge > k + 1))) begin
                rstn = 0;
                brk_rst_req = 0;
                rst_hold = 2;
                #1;
                model_reset();
                check_all();
            end
            if (cyc % 500 == 250) brk_rst_req = 1;
            drive_inputs();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
